// File: rtl/inst_rom_loader.sv
// Instruction memory filled from a big-endian byte stream terminated by END_WORD,
// read back through a registered fetch port with one cycle of latency.
module inst_rom_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 200,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] END_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SH_W   = (DATA_W > 8) ? DATA_W - 8 : 8;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                overflow_q, overflow_d;
  logic                loaded_q, loaded_d;
  logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [SH_W+7:0]     cat_s;
  logic [DATA_W-1:0]   word_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                we_s;

  // The shift register keeps only the bytes already received; the word is
  // completed with the byte on the bus so it can be judged on its last edge.
  assign cat_s  = {shift_q, in_data};
  assign word_s = cat_s[DATA_W-1:0];

  // Only addresses below the stored count are readable, which also keeps the
  // array index in range for any fetch_addr.
  always_comb begin
    if ({1'b0, fetch_addr} < word_count_q) begin
      rd_word_s = mem[fetch_addr];
    end else begin
      rd_word_s = END_WORD;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    word_count_d  = word_count_q;
    overflow_d    = overflow_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    we_s          = 1'b0;
    case (state_q)
      S_IDLE: begin
        byte_idx_d   = '0;
        word_count_d = '0;
        overflow_d   = 1'b0;
        if (load_start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          shift_d = cat_s[SH_W-1:0];
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (word_s == END_WORD) begin
              state_d = S_RUN;
            end else if (word_count_q < DEPTH_C) begin
              we_s         = 1'b1;
              word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + {{(BIDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          shift_d = shift_q;
        end
      end
      S_RUN: begin
        if (fetch_en) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = rd_word_s;
        end else begin
          fetch_valid_d = 1'b0;
        end
        if (load_start) begin
          state_d      = S_LOAD;
          byte_idx_d   = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    loaded_d = (state_d == S_RUN);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_idx_q    <= '0;
      shift_q       <= '0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
      loaded_q      <= 1'b0;
      fetch_data_q  <= END_WORD;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      shift_q       <= shift_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
      loaded_q      <= loaded_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Program storage survives reset; word_count gates what is readable.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[word_count_q[ADDR_W-1:0]] <= word_s;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign loaded      = loaded_q;
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomised bench: two loaders (DEPTH 200 and DEPTH 4) share one stimulus stream
// and are checked against a program-list reference model.
module tb_inst_rom_loader;

  localparam int          D0    = 200;
  localparam int          D1    = 4;
  localparam logic [31:0] END_W = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        fetch_en = 1'b0;
  logic [7:0]  fa = 8'h00;

  logic        in_ready0, in_ready1, fv0, fv1, ld0, ld1, ov0, ov1;
  logic [31:0] fd0, fd1;
  logic [8:0]  wc0;
  logic [2:0]  wc1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] prog[$];
  logic [31:0] wq[$];
  logic        exp_loaded = 1'b0;

  inst_rom_loader #(.DEPTH(D0)) dut0 (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready0), .fetch_en(fetch_en),
    .fetch_addr(fa), .fetch_data(fd0), .fetch_valid(fv0), .loaded(ld0),
    .word_count(wc0), .overflow(ov0)
  );

  inst_rom_loader #(.DEPTH(D1)) dut1 (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready1), .fetch_en(fetch_en),
    .fetch_addr(fa[1:0]), .fetch_data(fd1), .fetch_valid(fv1), .loaded(ld1),
    .word_count(wc1), .overflow(ov1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the stored image is the first min(n, depth) program words.
  function automatic int exp_count(input int k);
    int dep;
    dep = (k == 0) ? D0 : D1;
    return (prog.size() < dep) ? prog.size() : dep;
  endfunction

  function automatic logic [31:0] exp_fetch(input int k, input int a);
    int ak;
    ak = (k == 0) ? a : (a % D1);
    return (ak < exp_count(k)) ? prog[ak] : END_W;
  endfunction

  task automatic check_status(input string tag);
    check_val({tag, "_ready0"}, in_ready0, 1'b0);
    check_val({tag, "_ready1"}, in_ready1, 1'b0);
    check_val({tag, "_loaded0"}, ld0, exp_loaded);
    check_val({tag, "_loaded1"}, ld1, exp_loaded);
    check_val({tag, "_count0"}, wc0, exp_count(0));
    check_val({tag, "_count1"}, wc1, exp_count(1));
    check_val({tag, "_ovf0"}, ov0, prog.size() > D0);
    check_val({tag, "_ovf1"}, ov1, prog.size() > D1);
  endtask

  task automatic pulse_start(input bit with_fetch, input int a);
    load_start = 1'b1;
    fetch_en   = with_fetch;
    fa         = 8'(a);
    @(negedge clk);
    load_start = 1'b0;
    fetch_en   = 1'b0;
    if (with_fetch) begin
      check_val("start_fetch_valid", fv0, 1'b1);
      check_val("start_fetch_data0", fd0, exp_fetch(0, a));
      check_val("start_fetch_data1", fd1, exp_fetch(1, a));
    end
    check_val("start_loaded_drop", ld0, 1'b0);
    check_val("start_ready", in_ready0, 1'b1);
    exp_loaded = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid   = 1'b0;
        in_data    = 8'($urandom);
        load_start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      load_start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready0) check_val("ready_timeout", in_ready0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic load_prog(input string tag, input bit gaps, input bit with_fetch, input int a);
    pulse_start(with_fetch, a);
    foreach (wq[i]) send_word(wq[i], gaps);
    send_word(END_W, gaps);
    prog = wq;
    exp_loaded = 1'b1;
    check_status(tag);
  endtask

  task automatic fetch_seq(input int start, input int count, input bit rnd);
    int a;
    logic [31:0] e0, e1;
    e0 = fd0;
    e1 = fd1;
    for (int i = 0; i < count; i++) begin
      a = rnd ? int'($urandom_range(0, 255)) : start + i;
      fetch_en = 1'b1;
      fa = 8'(a);
      @(negedge clk);
      e0 = exp_fetch(0, a);
      e1 = exp_fetch(1, a);
      check_val("fetch_valid0", fv0, 1'b1);
      check_val("fetch_valid1", fv1, 1'b1);
      check_val($sformatf("fetch0_a%0d", a), fd0, e0);
      check_val($sformatf("fetch1_a%0d", a), fd1, e1);
    end
    fetch_en = 1'b0;
    @(negedge clk);
    check_val("fetch_idle_valid0", fv0, 1'b0);
    check_val("fetch_idle_hold0", fd0, e0);
    check_val("fetch_idle_hold1", fd1, e1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prog.delete();
    check_status("reset");
    check_val("reset_fetch_data", fd0, END_W);
    check_val("reset_fetch_valid", fv0, 1'b0);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    check_val("idle_fetch_valid0", fv0, 1'b0);
    check_val("idle_fetch_valid1", fv1, 1'b0);

    // basic load
    wq.delete();
    wq.push_back(32'h2001_0000);
    wq.push_back(32'hafdf_0000);
    load_prog("basic", 1'b0, 1'b0, 0);
    fetch_seq(0, 3, 1'b0);

    // gapped stream, back-to-back fetch
    wq.delete();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      if (w == END_W) w = 32'h0;
      wq.push_back(w);
    end
    load_prog("gapped", 1'b1, 1'b0, 0);
    fetch_seq(0, 6, 1'b0);
    fetch_seq(0, 8, 1'b1);

    // overflow on the small instance; fetch coincides with load_start
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom & 32'h7fff_ffff);
    load_prog("overflow", 1'b1, 1'b1, 1);
    fetch_seq(0, 6, 1'b0);
    fetch_seq(199, 2, 1'b0);
    fetch_seq(255, 1, 1'b0);

    // reload from RUN
    wq.delete();
    wq.push_back(32'h0800_0000);
    load_prog("reload", 1'b0, 1'b1, 3);
    fetch_seq(1, 1, 1'b0);
    fetch_seq(0, 1, 1'b0);

    // reset after three bytes of a word
    pulse_start(1'b0, 0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prog.delete();
    exp_loaded = 1'b0;
    check_status("midreset");
    fetch_en = 1'b1;
    fa = 8'h00;
    @(negedge clk);
    fetch_en = 1'b0;
    check_val("midreset_no_fetch", fv0, 1'b0);
    wq.delete();
    wq.push_back(32'h1234_5678);
    wq.push_back(32'h9abc_def0);
    load_prog("after_reset", 1'b1, 1'b0, 0);
    fetch_seq(0, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Parametrised instruction memory for the core, with a byte-stream program loader and a registered fetch port.
- Replaces fixed constant program images: a host streams a program in bytes, big-endian, terminated by END_WORD.
- Once the program is loaded, the core fetches from it with one-cycle read latency.
- Sits between the host byte source (UART receiver) and the core fetch stage.

Parameters:
- DATA_W, 32: instruction word width in bits. Must be a multiple of 8.
- DEPTH, 200: number of instruction words stored.
- ADDR_W, $clog2(DEPTH): width of the fetch address.
- END_WORD, 32'hffffffff (DATA_W bits, all ones): load terminator, and the value returned for any unloaded address.
- BYTES (derived, not overridable): DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- load_start  in  1  single-cycle pulse that begins a program load.
- in_data  in  8  program byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address.
- fetch_data  out  DATA_W  fetched instruction, registered.
- fetch_valid  out  1  fetch_data valid this cycle (1-cycle pulse).
- loaded  out  1  program loaded; fetch enabled.
- word_count  out  ADDR_W+1  number of words stored by the last load.
- overflow  out  1  sticky: program exceeded DEPTH words.

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 0, fetch_valid = 0, loaded = 0, overflow = 0.
  - word_count = 0, byte index = 0, fetch_data = END_WORD.
  - Memory array is not cleared.
- Clock, reset and handshakes:
  - One clock domain; all outputs are registered except in_ready.
  - in_ready = (state == LOAD), combinational from the state register.
  - A byte is accepted on a cycle where in_valid && in_ready.
- IDLE:
  - load_start -> LOAD next cycle.
  - Clears word_count, byte index and overflow; loaded = 0.
- LOAD:
  - Accepted bytes fill a shift register; the first byte lands in the MSB byte.
  - On acceptance of byte BYTES-1 (byte index wraps to 0), the assembled word W is evaluated on that same edge (W includes the current in_data):
    - W == END_WORD: not stored, not counted. Go to RUN; loaded = 1 next cycle.
    - word_count < DEPTH: mem[word_count] <= W and word_count += 1 on the same edge.
    - word_count == DEPTH: W is discarded, overflow <= 1, and the load stays in LOAD until the terminator arrives.
  - load_start during LOAD is ignored.
  - No timeout; gaps in in_valid are allowed.
- RUN:
  - fetch_en at cycle N -> at cycle N+1, fetch_valid = 1 and fetch_data = mem[fetch_addr] if fetch_addr < word_count, else END_WORD.
  - Back-to-back fetches are sustained, one per cycle.
  - Without a fetch: fetch_valid = 0 and fetch_data holds its value.
  - load_start in RUN -> LOAD (reload). loaded drops on the next cycle; counters clear as in IDLE.
  - If fetch_en coincides with load_start, the fetch is still served.
- Fetch outside RUN: ignored; fetch_valid stays 0.
- rst mid-load: returns to IDLE on the next edge and discards any partial word. Memory contents remain, but word_count = 0, so nothing is fetchable until a new load completes.
- A fetch_addr >= DEPTH is treated as an unloaded address: END_WORD is returned with no out-of-range array access.
- Width rule: word_count saturates at DEPTH and never wraps.

Test Plan:
- Reset then idle: rst for 2 cycles, then observe -> in_ready = 0, loaded = 0, word_count = 0, fetch_en gives no fetch_valid.
- Basic load/fetch:
  - Stimulus: load_start, then bytes 20 01 00 00, af df 00 00, ff ff ff ff.
  - Required: word_count = 2 and loaded = 1.
  - Fetch addr 0 -> 32'h20010000, addr 1 -> 32'hafdf0000, each exactly 1 cycle after fetch_en.
  - Fetch addr 2 -> 32'hffffffff.
- Gapped stream and back-to-back fetch:
  - Stimulus: in_valid toggled randomly while loading 5 words; fetch_en held high for 6 cycles at addrs 0..5.
  - Required: 6 consecutive fetch_valid pulses with data matching the 5 words, then END_WORD.
- Overflow:
  - Stimulus: DEPTH = 4, load 6 words plus the terminator.
  - Required: word_count = 4, overflow = 1, words 0..3 intact, loaded = 1 after the terminator.
- Reload and reset mid-operation:
  - Stimulus: in RUN, load_start and load 1 word, 32'h08000000.
  - Required: loaded goes 0 then 1, word_count = 1, fetch addr 1 -> END_WORD.
  - Stimulus: rst after 3 bytes of a word.
  - Required: IDLE, word_count = 0, a following load starts cleanly at byte 0.
